xif_coproc_arbiter: RTL and testbench

XIF_COPROC_ARBITER -- requirements
Module: xif_coproc_arbiter

---
 rtl/xif_coproc_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_xif_coproc_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/xif_coproc_arbiter.sv
// ----------------------------------------------------------------------------
// xif_coproc_arbiter
//   Shares one coprocessor issue/result interface among NUM_REQ requesters.
//   Requesters are granted round-robin. Each accepted instruction gets an
//   arbiter-owned coprocessor ID (a slot in a 2**ID_WIDTH table). The table
//   remembers the owner and the requester-local ID, so results can be routed
//   back to the correct requester.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     per-requester offload handshake (capture cycle)
//   req_instr_i, req_id_i   packed per-requester instruction / local ID
//   req_resp_valid_o        per-requester issue response pulse
//   req_resp_accept_o       issue response verdict (0 when no pulse)
//   cop_valid_o/ready_i     coprocessor issue handshake, cop_accept_i verdict
//   cop_instr_o, cop_id_o   issued instruction and allocated slot ID
//   cop_result_*            coprocessor result channel (ID, data, handshake)
//   res_valid_o/ready_i     per-requester result handshake
//   res_id_o, res_data_o    local ID and data of the routed result
//   err_o                   sticky flag: result arrived for an unallocated ID
// ----------------------------------------------------------------------------
module xif_coproc_arbiter #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_REQ  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [32*NUM_REQ-1:0]       req_instr_i,
    input  logic [ID_WIDTH*NUM_REQ-1:0] req_id_i,
    output logic [NUM_REQ-1:0]          req_resp_valid_o,
    output logic                        req_resp_accept_o,
    output logic                        cop_valid_o,
    input  logic                        cop_ready_i,
    input  logic                        cop_accept_i,
    output logic [31:0]                 cop_instr_o,
    output logic [ID_WIDTH-1:0]         cop_id_o,
    input  logic                        cop_result_valid_i,
    output logic                        cop_result_ready_o,
    input  logic [ID_WIDTH-1:0]         cop_result_id_i,
    input  logic [31:0]                 cop_result_data_i,
    output logic [NUM_REQ-1:0]          res_valid_o,
    input  logic [NUM_REQ-1:0]          res_ready_i,
    output logic [ID_WIDTH-1:0]         res_id_o,
    output logic [31:0]                 res_data_o,
    output logic                        err_o
);

    localparam int DEPTH = 2 ** ID_WIDTH;
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [PW-1:0]         grant_q, grant_d;
    logic [31:0]           instr_q, instr_d;
    logic [ID_WIDTH-1:0]   lid_q, lid_d;
    logic [ID_WIDTH-1:0]   cop_id_q, cop_id_d;
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic                  err_q, err_d;
    logic [PW-1:0]         owner_q    [DEPTH];
    logic [ID_WIDTH-1:0]   slot_lid_q [DEPTH];
    logic                  tbl_we;

    logic                  free_found, gnt_found;
    logic [ID_WIDTH-1:0]   free_idx;
    logic [PW-1:0]         gnt_idx;
    logic [PW-1:0]         res_owner;

    assign cop_instr_o = instr_q;
    assign cop_id_o    = cop_id_q;
    assign res_data_o  = cop_result_data_i;
    assign err_o       = err_q;
    assign res_owner   = owner_q[cop_result_id_i];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        state_d            = state_q;
        rr_d               = rr_q;
        grant_d            = grant_q;
        instr_d            = instr_q;
        lid_d              = lid_q;
        cop_id_d           = cop_id_q;
        busy_d             = busy_q;
        err_d              = err_q;
        tbl_we             = 1'b0;
        req_ready_o        = '0;
        req_resp_valid_o   = '0;
        req_resp_accept_o  = 1'b0;
        cop_valid_o        = 1'b0;
        cop_result_ready_o = 1'b0;
        res_valid_o        = '0;
        res_id_o           = '0;

        // Lowest free slot, from the registered busy vector only: a slot
        // released this cycle becomes allocatable next cycle.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = ID_WIDTH'(i);
            end
        end

        // Round-robin search starting at rr_q; the downward loop lets the
        // nearest requester to the pointer win.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid_i[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end

        // Reset suppresses all handshakes in the cycle it is asserted, which
        // also drops a pending issue without a response pulse.
        if (!rst_i) begin
            if (cop_result_valid_i) begin
                if (busy_q[cop_result_id_i]) begin
                    res_valid_o[res_owner] = 1'b1;
                    res_id_o               = slot_lid_q[cop_result_id_i];
                    cop_result_ready_o     = res_ready_i[res_owner];
                    if (res_ready_i[res_owner]) busy_d[cop_result_id_i] = 1'b0;
                end else begin
                    // Unknown ID: swallow it so the coprocessor never stalls.
                    cop_result_ready_o = 1'b1;
                    err_d              = 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (gnt_found && free_found) begin
                        req_ready_o[gnt_idx] = 1'b1;
                        instr_d  = req_instr_i[32*gnt_idx +: 32];
                        lid_d    = req_id_i[ID_WIDTH*gnt_idx +: ID_WIDTH];
                        grant_d  = gnt_idx;
                        cop_id_d = free_idx;
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    cop_valid_o = 1'b1;
                    if (cop_ready_i) begin
                        req_resp_valid_o[grant_q] = 1'b1;
                        req_resp_accept_o         = cop_accept_i;
                        if (cop_accept_i) begin
                            busy_d[cop_id_q] = 1'b1;
                            tbl_we           = 1'b1;
                        end
                        rr_d    = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Captured issue payload is only meaningful in ISSUE, so it needs no reset.
    always_ff @(posedge clk_i) begin
        grant_q  <= grant_d;
        instr_q  <= instr_d;
        lid_q    <= lid_d;
        cop_id_q <= cop_id_d;
    end

    // NOTE: the owner/local-ID table is not reset; busy_q alone decides
    // whether an entry is valid, which keeps the table a plain RAM.
    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            owner_q[cop_id_q]    <= grant_q;
            slot_lid_q[cop_id_q] <= lid_q;
        end
    end

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Randomized bench for xif_coproc_arbiter. A transaction-level model (one
// pending issue record plus a slot table) predicts every output each cycle.
module tb_xif_coproc_arbiter;

    localparam int IDW   = 4;
    localparam int N     = 2;
    localparam int DEPTH = 2 ** IDW;
    localparam int CYCLES = 20000;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_valid_i, req_ready_o, req_resp_valid_o;
    logic [32*N-1:0]  req_instr_i;
    logic [IDW*N-1:0] req_id_i;
    logic             req_resp_accept_o, cop_valid_o, cop_ready_i, cop_accept_i;
    logic [31:0]      cop_instr_o;
    logic [IDW-1:0]   cop_id_o;
    logic             cop_result_valid_i, cop_result_ready_o;
    logic [IDW-1:0]   cop_result_id_i;
    logic [31:0]      cop_result_data_i;
    logic [N-1:0]     res_valid_o, res_ready_i;
    logic [IDW-1:0]   res_id_o;
    logic [31:0]      res_data_o;
    logic             err_o;

    xif_coproc_arbiter #(.ID_WIDTH(IDW), .NUM_REQ(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_instr_i(req_instr_i), .req_id_i(req_id_i),
        .req_resp_valid_o(req_resp_valid_o), .req_resp_accept_o(req_resp_accept_o),
        .cop_valid_o(cop_valid_o), .cop_ready_i(cop_ready_i), .cop_accept_i(cop_accept_i),
        .cop_instr_o(cop_instr_o), .cop_id_o(cop_id_o),
        .cop_result_valid_i(cop_result_valid_i), .cop_result_ready_o(cop_result_ready_o),
        .cop_result_id_i(cop_result_id_i), .cop_result_data_i(cop_result_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_id_o(res_id_o), .res_data_o(res_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: at most one instruction in flight toward the coprocessor.
    typedef struct {
        bit             busy;
        int             owner;
        logic [IDW-1:0] lid;
    } slot_t;

    slot_t          m_slot [DEPTH];
    bit             m_pend;
    int             m_grant;
    logic [31:0]    m_instr;
    logic [IDW-1:0] m_lid, m_cop_id;
    int             m_rr;
    bit             m_err;

    task automatic model_reset();
        foreach (m_slot[i]) m_slot[i].busy = 1'b0;
        m_pend = 1'b0;
        m_rr   = 0;
        m_err  = 1'b0;
    endtask

    initial begin
        int p_res, p_rdy, p_acc, p_rrdy;
        int busy_list[$];
        model_reset();
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            logic [N-1:0]   e_rdy, e_resp, e_resv;
            logic           e_acc, e_copv, e_crr;
            logic [IDW-1:0] e_resid;
            int             g, fr;

            @(negedge clk_i);
            case ((cyc / 500) % 4)
                0: begin p_res = 10; p_rdy = 90;  p_acc = 95;  p_rrdy = 90;  end
                1: begin p_res = 40; p_rdy = 30;  p_acc = 50;  p_rrdy = 50;  end
                2: begin p_res = 80; p_rdy = 100; p_acc = 100; p_rrdy = 100; end
                default: begin p_res = 25; p_rdy = 60; p_acc = 80; p_rrdy = 70; end
            endcase

            rst_i = (cyc < 2) || ($urandom_range(299) == 0);
            for (int r = 0; r < N; r++) begin
                req_valid_i[r]              = ($urandom_range(99) < 70);
                req_instr_i[32*r +: 32]     = $urandom;
                req_id_i[IDW*r +: IDW]      = IDW'($urandom);
                res_ready_i[r]              = ($urandom_range(99) < p_rrdy);
            end
            cop_ready_i        = ($urandom_range(99) < p_rdy);
            cop_accept_i       = ($urandom_range(99) < p_acc);
            cop_result_valid_i = ($urandom_range(99) < p_res);
            cop_result_data_i  = $urandom;
            busy_list.delete();
            foreach (m_slot[i]) if (m_slot[i].busy) busy_list.push_back(i);
            if (busy_list.size() > 0 && $urandom_range(19) != 0)
                cop_result_id_i = IDW'(busy_list[$urandom_range(busy_list.size() - 1)]);
            else
                cop_result_id_i = IDW'($urandom);
            #1;

            // Expected outputs from the model's view of this cycle.
            e_rdy = '0; e_resp = '0; e_resv = '0;
            e_acc = 1'b0; e_copv = 1'b0; e_crr = 1'b0; e_resid = '0;
            g = -1; fr = -1;
            if (!rst_i) begin
                if (m_pend) begin
                    e_copv = 1'b1;
                    if (cop_ready_i) begin
                        e_resp[m_grant] = 1'b1;
                        e_acc = cop_accept_i;
                    end
                end else begin
                    for (int i = 0; i < DEPTH && fr < 0; i++) if (!m_slot[i].busy) fr = i;
                    for (int k = 0; k < N && g < 0; k++)
                        if (req_valid_i[(m_rr + k) % N]) g = (m_rr + k) % N;
                    if (fr >= 0 && g >= 0) e_rdy[g] = 1'b1;
                end
                if (cop_result_valid_i) begin
                    if (m_slot[cop_result_id_i].busy) begin
                        e_resv[m_slot[cop_result_id_i].owner] = 1'b1;
                        e_resid = m_slot[cop_result_id_i].lid;
                        e_crr   = res_ready_i[m_slot[cop_result_id_i].owner];
                    end else begin
                        e_crr = 1'b1;
                    end
                end
            end

            check("req_ready", req_ready_o, e_rdy);
            check("resp_valid", req_resp_valid_o, e_resp);
            check("resp_accept", req_resp_accept_o, e_acc);
            check("cop_valid", cop_valid_o, e_copv);
            if (e_copv) begin
                check("cop_instr", cop_instr_o, m_instr);
                check("cop_id", cop_id_o, m_cop_id);
            end
            check("res_valid", res_valid_o, e_resv);
            check("result_ready", cop_result_ready_o, e_crr);
            if (e_resv != '0) check("res_id", res_id_o, e_resid);
            check("res_data", res_data_o, cop_result_data_i);
            if (cyc > 0) check("err", err_o, m_err);

            // Advance the model across the coming clock edge.
            if (rst_i) begin
                model_reset();
            end else begin
                if (cop_result_valid_i) begin
                    if (!m_slot[cop_result_id_i].busy) m_err = 1'b1;
                    else if (e_crr) m_slot[cop_result_id_i].busy = 1'b0;
                end
                if (m_pend) begin
                    if (cop_ready_i) begin
                        if (cop_accept_i) begin
                            m_slot[m_cop_id].busy  = 1'b1;
                            m_slot[m_cop_id].owner = m_grant;
                            m_slot[m_cop_id].lid   = m_lid;
                        end
                        m_pend = 1'b0;
                        m_rr   = (m_grant + 1) % N;
                    end
                end else if (fr >= 0 && g >= 0) begin
                    m_pend   = 1'b1;
                    m_grant  = g;
                    m_instr  = req_instr_i[32*g +: 32];
                    m_lid    = req_id_i[IDW*g +: IDW];
                    m_cop_id = IDW'(fr);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
